mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  input  1  pipeline clock, all state on rising edge.
REQ-002 SHALL have ports: resetn  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: ws_allowin  input  1  writeback stage can accept.
REQ-004 SHALL have ports: ms_allowin  output  1  this stage can accept from EXE.
REQ-005 SHALL have ports: es_to_ms_valid  input  1  EXE offers an instruction.
REQ-006 SHALL have ports: es_to_ms_bus  input  76  {load_op[75:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-007 SHALL have ports: data_sram_data_ok  input  1  load data returned this cycle.
REQ-008 SHALL have ports: data_sram_rdata  input  32  returned word, valid only with data_ok.
REQ-009 SHALL have ports: ms_to_ws_valid  output  1  instruction offered to WB.
REQ-010 SHALL have ports: ms_to_ws_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-011 SHALL have ports: ms_to_ds_dest  output  5  dest for hazard check, 0 when stage empty or gr_we=0.
REQ-012 SHALL have ports: ms_to_ds_result  output  32  final_result for forwarding.
REQ-013 SHALL have ports: ms_to_ds_load_stall  output  1  load in stage and data not yet available.

Function
REQ-014 SHALL encode load_op one-hot: bit0 ld.w, bit1 ld.b, bit2 ld.h, bit3 ld.bu, bit4 ld.hu; all-zero = non-load.
REQ-015 SHALL hold a valid flag ms_valid and a 76-bit bus register; both load on a cycle with ms_allowin=1, valid <= es_to_ms_valid, bus only when es_to_ms_valid=1.
REQ-016 SHALL compute ms_allowin = !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go.
REQ-017 SHALL run a 3-state FSM: EMPTY (ms_valid=0), WAIT (valid load, no data), READY (valid, result available).
REQ-018 SHALL enter WAIT on accept of res_from_mem=1; enter READY on accept of res_from_mem=0; enter EMPTY on accept of es_to_ms_valid=0.
REQ-019 SHALL, in WAIT, set ms_ready_go = data_sram_data_ok; ms_ready_go=1 in READY; 0 in EMPTY.
REQ-020 SHALL, in WAIT with data_ok=1 and ws_allowin=0, capture data_sram_rdata into a 32-bit rdata_buf and move to READY.
REQ-021 SHALL, in WAIT with data_ok=1 and ws_allowin=1, pass rdata combinationally (zero extra latency) and follow REQ-018 for the next instruction.
REQ-022 SHALL, in READY for a load, use rdata_buf as load source; ignore data_ok outside WAIT.
REQ-023 SHALL select byte by alu_result[1:0] (00->[7:0], 01->[15:8], 10->[23:16], 11->[31:24]) and half by alu_result[1] (0->[15:0], 1->[31:16]).
REQ-024 SHALL extend: ld.b/ld.h sign-extend, ld.bu/ld.hu zero-extend, ld.w full word.
REQ-025 SHALL set final_result = extended load data if res_from_mem else alu_result.
REQ-026 SHALL set ms_to_ds_load_stall = (state==WAIT) & !data_sram_data_ok.
REQ-027 SHALL, with ws_allowin=0 in READY, hold bus, state and outputs stable.
REQ-028 SHALL accept a new instruction in the same cycle the current one leaves (back-to-back, one instruction per cycle when no load waits).

Reset
REQ-029 SHALL, while resetn=0 asynchronously, clear ms_valid, state=EMPTY, rdata_buf=0, bus register=0.
REQ-030 SHALL, during reset, drive ms_to_ws_valid=0, ms_allowin=1, ms_to_ds_dest=0, ms_to_ds_load_stall=0.
REQ-031 SHALL, on reset assertion mid-WAIT, discard the pending load; a data_ok arriving after release while EMPTY SHALL be ignored.

Verification
REQ-032 SHALL cover: add, alu_result=0x1234_5678, dest=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x12345678, ms_to_ds_dest=5.
REQ-033 SHALL cover: ld.b, addr[1:0]=11, data_ok with rdata=0x80FF_0000 -> final_result=0xFFFF_FF80; ld.bu same -> 0x0000_0080.
REQ-034 SHALL cover: ld.h, addr[1]=1, data_ok delayed 3 cycles with rdata=0x8001_1234 -> load_stall=1 for 3 cycles, ms_allowin=0, then final_result=0xFFFF_8001.
REQ-035 SHALL cover: ld.w data_ok=1 rdata=0xDEAD_BEEF while ws_allowin=0 for 2 cycles -> state READY, output 0xDEADBEEF held until ws_allowin=1, data_ok pulses meanwhile ignored.
REQ-036 SHALL cover: resetn low during WAIT -> ms_to_ws_valid=0 immediately, ms_allowin=1; post-release data_ok produces no output.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: holds one instruction from EXE, waits for load data when needed,
// and hands the aligned/extended result on to writeback.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [75:0] es_to_ms_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [4:0]  ms_to_ds_dest,
    output logic [31:0] ms_to_ds_result,
    output logic        ms_to_ds_load_stall
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        ms_valid_q, ms_valid_d;
    logic [75:0] bus_q, bus_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic [4:0]  load_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic        ms_ready_go;
    logic [31:0] load_src;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign {load_op, res_from_mem, gr_we, dest, alu_result, pc} = bus_q;

    always_comb begin
        ms_ready_go = 1'b0;
        case (state_q)
            ST_WAIT:  ms_ready_go = data_sram_data_ok;
            ST_READY: ms_ready_go = 1'b1;
            default:  ms_ready_go = 1'b0;
        endcase
    end

    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

    // In WAIT the returning word is used directly; once parked it comes from the buffer.
    assign load_src = (state_q == ST_WAIT) ? data_sram_rdata : rdata_buf_q;

    always_comb begin
        sel_byte = load_src[7:0];
        case (alu_result[1:0])
            2'b00: sel_byte = load_src[7:0];
            2'b01: sel_byte = load_src[15:8];
            2'b10: sel_byte = load_src[23:16];
            2'b11: sel_byte = load_src[31:24];
            default: sel_byte = load_src[7:0];
        endcase
        sel_half = alu_result[1] ? load_src[31:16] : load_src[15:0];
    end

    always_comb begin
        load_result = load_src;
        if (load_op[1])
            load_result = {{24{sel_byte[7]}}, sel_byte};
        else if (load_op[2])
            load_result = {{16{sel_half[15]}}, sel_half};
        else if (load_op[3])
            load_result = {24'd0, sel_byte};
        else if (load_op[4])
            load_result = {16'd0, sel_half};
    end

    assign final_result = res_from_mem ? load_result : alu_result;

    assign ms_to_ws_bus        = {gr_we, dest, final_result, pc};
    assign ms_to_ds_dest       = (ms_valid_q && gr_we) ? dest : 5'd0;
    assign ms_to_ds_result     = final_result;
    assign ms_to_ds_load_stall = (state_q == ST_WAIT) && !data_sram_data_ok;

    always_comb begin
        state_d     = state_q;
        ms_valid_d  = ms_valid_q;
        bus_d       = bus_q;
        rdata_buf_d = rdata_buf_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
            if (es_to_ms_valid) begin
                bus_d   = es_to_ms_bus;
                state_d = es_to_ms_bus[70] ? ST_WAIT : ST_READY;
            end else begin
                state_d = ST_EMPTY;
            end
        end else if (state_q == ST_WAIT && data_sram_data_ok) begin
            // WB is blocked: park the word so the result survives the stall.
            rdata_buf_d = data_sram_rdata;
            state_d     = ST_READY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_EMPTY;
            ms_valid_q  <= 1'b0;
            bus_q       <= 76'd0;
            rdata_buf_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            ms_valid_q  <= ms_valid_d;
            bus_q       <= bus_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table through a scoreboard, plus stall and reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [4:0]  ms_to_ds_dest;
    logic [31:0] ms_to_ds_result;
    logic        ms_to_ds_load_stall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  load_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs[9];
    logic [69:0] sb_q[$];

    mem_stage dut (
        .clk                 (clk),
        .resetn              (resetn),
        .ws_allowin          (ws_allowin),
        .ms_allowin          (ms_allowin),
        .es_to_ms_valid      (es_to_ms_valid),
        .es_to_ms_bus        (es_to_ms_bus),
        .data_sram_data_ok   (data_sram_data_ok),
        .data_sram_rdata     (data_sram_rdata),
        .ms_to_ws_valid      (ms_to_ws_valid),
        .ms_to_ws_bus        (ms_to_ws_bus),
        .ms_to_ds_dest       (ms_to_ds_dest),
        .ms_to_ds_result     (ms_to_ds_result),
        .ms_to_ds_load_stall (ms_to_ds_load_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every handshake into WB is checked against the oldest expected transfer.
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", ms_to_ws_bus, 70'd0);
                if (ms_to_ws_bus == 70'd0) begin
                    bad++;
                    $display("FAIL unexpected_output: got=zero bus want=no transfer");
                end
            end else begin
                chk("wb_bus", ms_to_ws_bus, sb_q.pop_front());
            end
        end
    end

    function automatic logic [75:0] mk_bus(input logic [4:0] op, input logic we,
                                           input logic [4:0] d, input logic [31:0] a,
                                           input logic [31:0] p);
        return {op, |op, we, d, a, p};
    endfunction

    task automatic send(input logic [4:0] op, input logic we, input logic [4:0] d,
                        input logic [31:0] a, input logic [31:0] p, input logic [31:0] res);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(op, we, d, a, p);
        sb_q.push_back({we, d, res, p});
    endtask

    initial begin
        vecs[0] = '{5'b00000, 1'b1, 5'd5,  32'h1234_5678, 32'h1C00_0000, 32'h0,          0, 32'h1234_5678};
        vecs[1] = '{5'b00010, 1'b1, 5'd6,  32'h0000_1003, 32'h1C00_0004, 32'h80FF_0000, 0, 32'hFFFF_FF80};
        vecs[2] = '{5'b01000, 1'b1, 5'd7,  32'h0000_1003, 32'h1C00_0008, 32'h80FF_0000, 0, 32'h0000_0080};
        vecs[3] = '{5'b00100, 1'b1, 5'd8,  32'h0000_2002, 32'h1C00_000C, 32'h8001_1234, 3, 32'hFFFF_8001};
        vecs[4] = '{5'b10000, 1'b1, 5'd9,  32'h0000_2000, 32'h1C00_0010, 32'h8001_1234, 1, 32'h0000_1234};
        vecs[5] = '{5'b00001, 1'b1, 5'd10, 32'h0000_0004, 32'h1C00_0014, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
        vecs[6] = '{5'b00010, 1'b1, 5'd11, 32'h0000_0001, 32'h1C00_0018, 32'h0000_7F00, 2, 32'h0000_007F};
        vecs[7] = '{5'b00100, 1'b1, 5'd12, 32'h0000_0000, 32'h1C00_001C, 32'h0000_F00D, 0, 32'hFFFF_F00D};
        vecs[8] = '{5'b00000, 1'b0, 5'd13, 32'hCAFE_F00D, 32'h1C00_0020, 32'h0,          0, 32'hCAFE_F00D};

        resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        #12;
        chk("rst_valid",   70'(ms_to_ws_valid), 70'd0);
        chk("rst_allowin", 70'(ms_allowin), 70'd1);
        chk("rst_dest",    70'(ms_to_ds_dest), 70'd0);
        chk("rst_stall",   70'(ms_to_ds_load_stall), 70'd0);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            send(vecs[i].load_op, vecs[i].gr_we, vecs[i].dest, vecs[i].alu, vecs[i].pc, vecs[i].exp_result);
            data_sram_data_ok = 1'b0;
            data_sram_rdata = $urandom;
            @(posedge clk); #1;
            es_to_ms_valid = 1'b0;
            if (vecs[i].load_op != 5'b0) begin
                for (int d = 0; d < vecs[i].delay; d++) begin
                    @(negedge clk);
                    chk("wait_stall",   70'(ms_to_ds_load_stall), 70'd1);
                    chk("wait_allowin", 70'(ms_allowin), 70'd0);
                    chk("wait_novalid", 70'(ms_to_ws_valid), 70'd0);
                    @(posedge clk); #1;
                end
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = vecs[i].rdata;
            end
            @(negedge clk);
            chk("vec_stall",   70'(ms_to_ds_load_stall), 70'd0);
            chk("vec_allowin", 70'(ms_allowin), 70'd1);
            chk("vec_dest",    70'(ms_to_ds_dest), 70'(vecs[i].gr_we ? vecs[i].dest : 5'd0));
            chk("vec_fwd",     70'(ms_to_ds_result), 70'(vecs[i].exp_result));
            @(posedge clk); #1;
            data_sram_data_ok = 1'b0;
        end

        // Back-to-back ALU ops: one per cycle with no bubbles.
        @(posedge clk); #1;
        send(5'b0, 1'b1, 5'd1, 32'h0000_0011, 32'h1C00_0100, 32'h0000_0011);
        @(posedge clk); #1;
        send(5'b0, 1'b1, 5'd2, 32'h0000_0022, 32'h1C00_0104, 32'h0000_0022);
        @(negedge clk);
        chk("b2b_allowin", 70'(ms_allowin), 70'd1);
        @(posedge clk); #1;
        send(5'b0, 1'b1, 5'd3, 32'h0000_0033, 32'h1C00_0108, 32'h0000_0033);
        @(negedge clk);
        chk("b2b_dest", 70'(ms_to_ds_dest), 70'd2);
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_drain", 70'(sb_q.size()), 70'd0);

        // ld.w returns while WB is blocked: result must be parked and held.
        ws_allowin = 1'b0;
        send(5'b00001, 1'b1, 5'd4, 32'h0000_0040, 32'h1C00_0200, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("hold0_valid",   70'(ms_to_ws_valid), 70'd1);
        chk("hold0_allowin", 70'(ms_allowin), 70'd0);
        chk("hold0_res",     70'(ms_to_ds_result), 70'hDEAD_BEEF);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111 * (c + 2);
            @(negedge clk);
            chk("hold_res",     70'(ms_to_ds_result), 70'hDEAD_BEEF);
            chk("hold_valid",   70'(ms_to_ws_valid), 70'd1);
            chk("hold_allowin", 70'(ms_allowin), 70'd0);
            chk("hold_stall",   70'(ms_to_ds_load_stall), 70'd0);
        end
        @(posedge clk); #1;
        data_sram_data_ok = 1'b0;
        ws_allowin = 1'b1;
        @(posedge clk); #1;
        chk("hold_drain", 70'(sb_q.size()), 70'd0);

        // Reset in WAIT drops the load; a late data_ok must not resurrect it.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(5'b00001, 1'b1, 5'd9, 32'h0000_0080, 32'h1C00_0300);
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("rw_stall", 70'(ms_to_ds_load_stall), 70'd1);
        #1 resetn = 1'b0;
        #1;
        chk("rw_valid",   70'(ms_to_ws_valid), 70'd0);
        chk("rw_allowin", 70'(ms_allowin), 70'd1);
        chk("rw_dest",    70'(ms_to_ds_dest), 70'd0);
        chk("rw_stall0",  70'(ms_to_ds_load_stall), 70'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_AAAA;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("post_valid", 70'(ms_to_ws_valid), 70'd0);
            chk("post_stall", 70'(ms_to_ds_load_stall), 70'd0);
            @(posedge clk); #1;
        end
        data_sram_data_ok = 1'b0;
        chk("final_drain", 70'(sb_q.size()), 70'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim did not finish, want finish before 50000");
        $fatal(1);
    end

endmodule
